// File: rtl/hyperram_responder.sv
// hyperram_responder
//   Device-side HyperRAM target for loopback and bench use. Runs entirely on
//   clk and oversamples dram_ck; every dram_ck edge (rise or fall) seen while
//   chip select is active moves exactly one byte. It decodes the 6-byte CA,
//   waits a fixed initial latency, then serves DDR reads/writes from a small
//   two-bank byte memory, or the ID0/ID1/CR0 register space.
//
// Ports
//   clk         system clock; dram_ck must hold each level >= 3 clk cycles
//   reset       asynchronous, active-high
//   dram_ck     bus clock from the host (sampled, not used as a clock)
//   dram_cs_l   chip select, active low
//   dram_rst_l  device reset, active low: FSM and CR0 only, memory kept
//   dq_in       data pins in
//   dq_out      data pins out
//   dq_oe       dq output enable
//   rwds_in     write byte mask, 1 = byte not written
//   rwds_out    latency indicator during CA, read strobe during read data
//   rwds_oe     rwds output enable
//   txn_count   transactions ended by chip select release (wraps)
//   err_flag    sticky: chip select released during CA or latency
//   state       (internal, hierarchically visible) current FSM state
module hyperram_responder #(
  parameter int MEM_AW   = 8,
  parameter int LATENCY  = 6,
  parameter int FIXED_2X = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dram_ck,
  input  logic        dram_cs_l,
  input  logic        dram_rst_l,
  input  logic [7:0]  dq_in,
  output logic [7:0]  dq_out,
  output logic        dq_oe,
  input  logic        rwds_in,
  output logic        rwds_out,
  output logic        rwds_oe,
  output logic [15:0] txn_count,
  output logic        err_flag
);

  localparam int LAT_EDGES = 2 * LATENCY * ((FIXED_2X != 0) ? 2 : 1);
  localparam int LCW       = $clog2(LAT_EDGES + 1);
  localparam int DEPTH     = 1 << MEM_AW;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(LAT_EDGES - 1);
  localparam logic [15:0] ID0_VAL = 16'h0C81;
  localparam logic [15:0] ID1_VAL = 16'h0001;
  localparam logic [15:0] CR0_RST = 16'h8F1F;

  typedef enum logic [2:0] {
    S_IDLE, S_CA, S_LATENCY, S_RD_DATA, S_WR_DATA, S_REG_WR
  } state_t;

  state_t state;

  // Two-flop input synchronisers. All bus inputs share the same depth so
  // dq/rwds stay aligned with the synchronised ck they were launched with.
  logic [1:0] ck_sr, cs_sr, rst_sr, rwds_sr;
  logic [7:0] dq_s1, dq_s2;
  logic       ck_prev, cs_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ck_sr   <= 2'b00;
      cs_sr   <= 2'b11;
      rst_sr  <= 2'b11;
      rwds_sr <= 2'b00;
      dq_s1   <= 8'h00;
      dq_s2   <= 8'h00;
      ck_prev <= 1'b0;
      cs_prev <= 1'b1;
    end else begin
      ck_sr   <= {ck_sr[0], dram_ck};
      cs_sr   <= {cs_sr[0], dram_cs_l};
      rst_sr  <= {rst_sr[0], dram_rst_l};
      rwds_sr <= {rwds_sr[0], rwds_in};
      dq_s1   <= dq_in;
      dq_s2   <= dq_s1;
      ck_prev <= ck_sr[1];
      cs_prev <= cs_sr[1];
    end
  end

  logic       ck_s, cs_s, dev_rst_n, rwds_s;
  logic [7:0] dq_s;
  logic       bus_edge, cs_fall;

  assign ck_s      = ck_sr[1];
  assign cs_s      = cs_sr[1];
  assign dev_rst_n = rst_sr[1];
  assign rwds_s    = rwds_sr[1];
  assign dq_s      = dq_s2;
  // Edges only count while selected; cs rising in the same clk is handled
  // with priority in the FSM, so that byte is dropped.
  assign bus_edge  = (ck_s != ck_prev) && !cs_s;
  assign cs_fall   = cs_prev && !cs_s;

  // CA shift register: 40 bits held, the 6th byte is combined on the fly.
  logic [39:0] ca_sr;
  logic [47:0] ca_next;
  logic [31:0] ca_addr;
  logic        ca_unused;

  assign ca_next   = {ca_sr, dq_s};
  assign ca_addr   = {ca_next[44:16], ca_next[2:0]};
  // ca[45] (burst type) and the reserved column bits carry no meaning here.
  assign ca_unused = ^{ca_next[45], ca_next[15:3]};

  logic [2:0]     ca_cnt;
  logic [LCW-1:0] lat_cnt;
  logic [31:0]    addr;
  logic           is_read, is_reg;
  logic [7:0]     reg_hi;
  logic [1:0]     reg_cnt;
  logic [15:0]    cr0;

  // Byte-lane memory; kept out of the reset domain so contents survive
  // both resets.
  logic [7:0] mem_hi [DEPTH];
  logic [7:0] mem_lo [DEPTH];

  logic [MEM_AW-1:0] mem_addr, mem_addr_inc;
  logic [31:0]       addr_next;
  logic [15:0]       rd_word;
  logic              wr_hi_en, wr_lo_en;

  assign mem_addr     = addr[MEM_AW-1:0];
  assign mem_addr_inc = mem_addr + 1'b1;
  // Register space keeps the full address; memory wraps at its depth.
  assign addr_next    = is_reg ? (addr + 32'd1) : 32'(mem_addr_inc);

  assign wr_hi_en = (state == S_WR_DATA) && bus_edge && dev_rst_n &&  ck_s && !rwds_s;
  assign wr_lo_en = (state == S_WR_DATA) && bus_edge && dev_rst_n && !ck_s && !rwds_s;

  always_ff @(posedge clk) begin
    if (wr_hi_en) mem_hi[mem_addr] <= dq_s;
    if (wr_lo_en) mem_lo[mem_addr] <= dq_s;
  end

  always_comb begin
    rd_word = {mem_hi[mem_addr], mem_lo[mem_addr]};
    if (is_reg) begin
      if (addr == 32'd0)      rd_word = ID0_VAL;
      else if (addr == 32'd1) rd_word = ID1_VAL;
      else                    rd_word = cr0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dq_out    <= 8'h00;
      dq_oe     <= 1'b0;
      rwds_out  <= 1'b0;
      rwds_oe   <= 1'b0;
      txn_count <= 16'h0000;
      err_flag  <= 1'b0;
      cr0       <= CR0_RST;
      ca_sr     <= '0;
      ca_cnt    <= 3'd0;
      lat_cnt   <= '0;
      addr      <= 32'd0;
      is_read   <= 1'b0;
      is_reg    <= 1'b0;
      reg_hi    <= 8'h00;
      reg_cnt   <= 2'd0;
    end else if (!dev_rst_n) begin
      state    <= S_IDLE;
      dq_oe    <= 1'b0;
      rwds_oe  <= 1'b0;
      rwds_out <= 1'b0;
      cr0      <= CR0_RST;
    end else if (state != S_IDLE && cs_s) begin
      // Host ended the transaction; partially written words are kept.
      state     <= S_IDLE;
      dq_oe     <= 1'b0;
      rwds_oe   <= 1'b0;
      rwds_out  <= 1'b0;
      txn_count <= txn_count + 16'd1;
      if (state == S_CA || state == S_LATENCY) err_flag <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          dq_oe   <= 1'b0;
          rwds_oe <= 1'b0;
          if (cs_fall) begin
            state    <= S_CA;
            ca_cnt   <= 3'd0;
            rwds_oe  <= 1'b1;
            rwds_out <= (FIXED_2X != 0);
          end
        end
        S_CA: begin
          if (bus_edge) begin
            ca_sr <= ca_next[39:0];
            if (ca_cnt == 3'd5) begin
              rwds_oe  <= 1'b0;
              rwds_out <= 1'b0;
              is_read  <= ca_next[47];
              is_reg   <= ca_next[46];
              addr     <= ca_addr;
              lat_cnt  <= '0;
              reg_cnt  <= 2'd0;
              // Register writes take effect with zero latency.
              state    <= (!ca_next[47] && ca_next[46]) ? S_REG_WR : S_LATENCY;
            end else begin
              ca_cnt <= ca_cnt + 3'd1;
            end
          end
        end
        S_LATENCY: begin
          if (bus_edge) begin
            if (lat_cnt == LAT_LAST) begin
              state <= is_read ? S_RD_DATA : S_WR_DATA;
              if (is_read) begin
                dq_oe    <= 1'b1;
                rwds_oe  <= 1'b1;
                rwds_out <= 1'b0;
              end
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
        end
        S_RD_DATA: begin
          if (bus_edge) begin
            // rwds follows the new ck level: edge-aligned read strobe.
            dq_out   <= ck_s ? rd_word[15:8] : rd_word[7:0];
            rwds_out <= ck_s;
            if (!ck_s) addr <= addr_next;
          end
        end
        S_WR_DATA: begin
          if (bus_edge && !ck_s) addr <= addr_next;
        end
        S_REG_WR: begin
          if (bus_edge) begin
            if (reg_cnt == 2'd0) begin
              reg_hi  <= dq_s;
              reg_cnt <= 2'd1;
            end else if (reg_cnt == 2'd1) begin
              cr0     <= {reg_hi, dq_s};
              reg_cnt <= 2'd2;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyperram_responder.sv
// tb_hyperram_responder
//   Directed bench for hyperram_responder. Instance a uses default
//   parameters; instance b uses MEM_AW=2 for the address wrap case. Both
//   share the bus pins except chip select. Expected read words are queued
//   in exp_q before each read burst and popped as bytes arrive.
module tb_hyperram_responder;

  logic        clk;
  logic        reset;
  logic        dram_ck;
  logic        cs_a, cs_b;
  logic        dram_rst_l;
  logic [7:0]  dq_in;
  logic        rwds_in;

  logic [7:0]  dq_out_a, dq_out_b;
  logic        dq_oe_a, dq_oe_b;
  logic        rwds_out_a, rwds_out_b;
  logic        rwds_oe_a, rwds_oe_b;
  logic [15:0] txn_a, txn_b;
  logic        err_a, err_b;

  int checks = 0;
  int errors = 0;
  logic sel_b = 1'b0;
  logic [15:0] exp_q[$];

  hyperram_responder dut_a (
    .clk(clk), .reset(reset), .dram_ck(dram_ck), .dram_cs_l(cs_a),
    .dram_rst_l(dram_rst_l), .dq_in(dq_in), .dq_out(dq_out_a), .dq_oe(dq_oe_a),
    .rwds_in(rwds_in), .rwds_out(rwds_out_a), .rwds_oe(rwds_oe_a),
    .txn_count(txn_a), .err_flag(err_a)
  );

  hyperram_responder #(.MEM_AW(2)) dut_b (
    .clk(clk), .reset(reset), .dram_ck(dram_ck), .dram_cs_l(cs_b),
    .dram_rst_l(dram_rst_l), .dq_in(dq_in), .dq_out(dq_out_b), .dq_oe(dq_oe_b),
    .rwds_in(rwds_in), .rwds_out(rwds_out_b), .rwds_oe(rwds_oe_b),
    .txn_count(txn_b), .err_flag(err_b)
  );

  // Observation of whichever instance is selected.
  logic [7:0]  o_dq;
  logic        o_dq_oe, o_rwds, o_rwds_oe, o_err;
  logic [15:0] o_txn;
  assign o_dq      = sel_b ? dq_out_b   : dq_out_a;
  assign o_dq_oe   = sel_b ? dq_oe_b    : dq_oe_a;
  assign o_rwds    = sel_b ? rwds_out_b : rwds_out_a;
  assign o_rwds_oe = sel_b ? rwds_oe_b  : rwds_oe_a;
  assign o_txn     = sel_b ? txn_b      : txn_a;
  assign o_err     = sel_b ? err_b      : err_a;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks. One bus edge every 4 clk; outputs settle 3 clk after it.
  task automatic cs_set(input logic v);
    if (sel_b) cs_b = v;
    else       cs_a = v;
  endtask

  task automatic bus_edge(input logic [7:0] d, input logic m);
    dq_in   = d;
    rwds_in = m;
    dram_ck = ~dram_ck;
    tick(4);
  endtask

  task automatic begin_ca(input string tag, input logic [47:0] ca);
    cs_set(1'b0);
    tick(4);
    check({tag, "_ca_rwds_oe"}, 32'(o_rwds_oe), 32'd1);
    check({tag, "_ca_rwds"}, 32'(o_rwds), 32'd1);
    for (int i = 0; i < 6; i++) bus_edge(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic latency(input int n);
    for (int i = 0; i < n; i++) bus_edge(8'h00, 1'b0);
  endtask

  task automatic end_txn();
    cs_set(1'b1);
    tick(4);
  endtask

  task automatic wr_word(input logic [15:0] w, input logic mhi, input logic mlo);
    bus_edge(w[15:8], mhi);
    bus_edge(w[7:0], mlo);
  endtask

  task automatic rd_word(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    bus_edge(8'h00, 1'b0);
    check({tag, "_hi"}, 32'(o_dq), 32'(e[15:8]));
    check({tag, "_strobe_hi"}, 32'(o_rwds), 32'd1);
    bus_edge(8'h00, 1'b0);
    check({tag, "_lo"}, 32'(o_dq), 32'(e[7:0]));
    check({tag, "_strobe_lo"}, 32'(o_rwds), 32'd0);
  endtask

  initial begin
    reset = 1'b1; cs_a = 1'b1; cs_b = 1'b1; dram_rst_l = 1'b1;
    dram_ck = 1'b0; dq_in = 8'h00; rwds_in = 1'b0;

    // 1: reset held, ck toggling, nothing selected
    for (int i = 0; i < 6; i++) begin
      dram_ck = ~dram_ck;
      tick(2);
    end
    check("rst_dq", 32'(dq_out_a), 32'd0);
    check("rst_dq_oe", 32'(dq_oe_a), 32'd0);
    check("rst_rwds", 32'(rwds_out_a), 32'd0);
    check("rst_rwds_oe", 32'(rwds_oe_a), 32'd0);
    check("rst_txn", 32'(txn_a), 32'd0);
    check("rst_err", 32'(err_a), 32'd0);
    check("rst_b_oe", 32'({dq_oe_b, rwds_oe_b}), 32'd0);
    reset = 1'b0;
    tick(4);
    check("post_rst_txn", 32'(txn_a), 32'd0);

    // 2: write word 5 = A55A, read it back after 24 latency edges
    begin_ca("t2w", 48'h20_00_00_00_00_05);
    check("t2w_lat_rwds_oe", 32'(o_rwds_oe), 32'd0);
    latency(24);
    check("t2w_dq_oe", 32'(o_dq_oe), 32'd0);
    wr_word(16'hA55A, 1'b0, 1'b0);
    end_txn();
    begin_ca("t2r", 48'hA0_00_00_00_00_05);
    latency(23);
    check("t2r_oe_before_data", 32'(o_dq_oe), 32'd0);
    latency(1);
    check("t2r_dq_oe", 32'(o_dq_oe), 32'd1);
    check("t2r_rwds_oe", 32'(o_rwds_oe), 32'd1);
    exp_q.push_back(16'hA55A);
    rd_word("t2r_w5");
    end_txn();
    check("t2_txn", 32'(o_txn), 32'd2);
    check("t2_err", 32'(o_err), 32'd0);
    check("t2_idle_oe", 32'({o_dq_oe, o_rwds_oe}), 32'd0);

    // 3: masked low byte keeps old FF
    begin_ca("t3a", 48'h20_00_00_00_00_07);
    latency(24);
    wr_word(16'hFFFF, 1'b0, 1'b0);
    end_txn();
    begin_ca("t3b", 48'h20_00_00_00_00_07);
    latency(24);
    wr_word(16'h1234, 1'b0, 1'b1);
    end_txn();
    begin_ca("t3r", 48'hA0_00_00_00_00_07);
    latency(24);
    exp_q.push_back(16'h12FF);
    rd_word("t3r_w7");
    end_txn();
    check("t3_txn", 32'(o_txn), 32'd5);

    // 4: register reads (ID0, ID1, CR0), register write, read back CR0
    begin_ca("t4r", 48'hC0_00_00_00_00_00);
    latency(24);
    exp_q.push_back(16'h0C81);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h8F1F);
    rd_word("t4r_id0");
    rd_word("t4r_id1");
    rd_word("t4r_cr0");
    end_txn();
    begin_ca("t4w", 48'h60_00_01_00_00_00);
    wr_word(16'h8F17, 1'b0, 1'b0);
    bus_edge(8'h55, 1'b0);
    bus_edge(8'hAA, 1'b0);
    end_txn();
    begin_ca("t4c", 48'hE0_00_01_00_00_00);
    latency(24);
    exp_q.push_back(16'h8F17);
    rd_word("t4c_cr0");
    end_txn();
    check("t4_txn", 32'(o_txn), 32'd8);

    // dram_rst_l pulse: CR0 back to default, counters kept
    dram_rst_l = 1'b0;
    tick(4);
    check("drst_oe", 32'({o_dq_oe, o_rwds_oe}), 32'd0);
    dram_rst_l = 1'b1;
    tick(4);
    check("drst_txn", 32'(o_txn), 32'd8);
    begin_ca("t4d", 48'hC0_00_01_00_00_00);
    latency(24);
    exp_q.push_back(16'h8F1F);
    rd_word("t4d_cr0");
    end_txn();

    // 5: MEM_AW=2 instance, burst read wraps past word 3
    sel_b = 1'b1;
    begin_ca("t5w", 48'h20_00_00_00_00_00);
    latency(24);
    for (int i = 0; i < 4; i++) wr_word(16'(i), 1'b0, 1'b0);
    end_txn();
    begin_ca("t5r", 48'hA0_00_00_00_00_03);
    latency(24);
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    for (int i = 0; i < 5; i++) rd_word($sformatf("t5r_b%0d", i));
    end_txn();
    check("t5_txn_b", 32'(o_txn), 32'd2);
    check("t5_err_b", 32'(o_err), 32'd0);
    sel_b = 1'b0;

    // 6: abort in latency, then a normal read
    check("t6_err_before", 32'(o_err), 32'd0);
    begin_ca("t6a", 48'hA0_00_00_00_00_05);
    latency(4);
    cs_set(1'b1);
    tick(3);
    check("t6_err", 32'(o_err), 32'd1);
    check("t6_oe", 32'({o_dq_oe, o_rwds_oe}), 32'd0);
    check("t6_txn", 32'(o_txn), 32'd10);
    tick(1);
    begin_ca("t6r", 48'hA0_00_00_00_00_05);
    latency(24);
    exp_q.push_back(16'hA55A);
    rd_word("t6r_w5");
    end_txn();
    check("t6_txn_after", 32'(o_txn), 32'd11);
    check("t6_err_sticky", 32'(o_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
